// File: rtl/johnson_decoder_checker.sv
// Johnson-code receive checker: decodes an N-bit Johnson word to a phase index,
// flags illegal codes and sequence breaks, declares lock, and counts errors.
module johnson_decoder_checker #(
  parameter int unsigned N          = 4,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned ALLOW_HOLD = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  logic [N-1:0]               code_in,
  output logic [$clog2(2*N)-1:0]     index,
  output logic                       index_valid,
  output logic                       illegal,
  output logic                       seq_err,
  output logic                       locked,
  output logic [7:0]                 err_count
);

  localparam int unsigned IW = $clog2(2*N);
  localparam int unsigned GW = 4;
  localparam int unsigned EW = 8;
  localparam logic [N-1:0]  ALL1    = {N{1'b1}};
  localparam logic [IW-1:0] IDX_MAX = IW'(2*N - 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_CNT);
  localparam logic [EW-1:0] ERR_MAX = {EW{1'b1}};

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] prev_q, prev_d;
  logic [GW-1:0] good_q, good_d;
  logic [IW-1:0] index_q, index_d;
  logic          index_valid_q, index_valid_d;
  logic          illegal_q, illegal_d;
  logic          seq_err_q, seq_err_d;
  logic          locked_q, locked_d;
  logic [EW-1:0] err_q, err_d;

  logic          legal_c;
  logic [IW-1:0] dec_idx_c;
  logic [IW-1:0] succ_c;
  logic          step_ok_c;
  logic          err_event_c;

  // Thermometer decode: low-aligned ones give k, high-aligned ones with z zeros give N+z
  always_comb begin
    legal_c   = 1'b0;
    dec_idx_c = '0;
    for (int unsigned k = 0; k <= N; k++) begin
      if (code_in == (ALL1 >> (N - k))) begin
        legal_c   = 1'b1;
        dec_idx_c = IW'(k);
      end
    end
    for (int unsigned z = 1; z < N; z++) begin
      if (code_in == (ALL1 << z)) begin
        legal_c   = 1'b1;
        dec_idx_c = IW'(N + z);
      end
    end
  end

  // Explicit wrap so non-power-of-two sequence lengths stay mod 2N
  always_comb begin
    succ_c    = (prev_q == IDX_MAX) ? '0 : prev_q + IW'(1);
    step_ok_c = (dec_idx_c == succ_c) || ((ALLOW_HOLD != 0) && (dec_idx_c == prev_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SEARCH;
      prev_q        <= '0;
      good_q        <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      good_q        <= good_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      illegal_q     <= illegal_d;
      seq_err_q     <= seq_err_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    good_d        = good_q;
    index_d       = index_q;
    index_valid_d = 1'b0;
    illegal_d     = 1'b0;
    seq_err_d     = 1'b0;
    locked_d      = locked_q;
    err_d         = err_q;
    err_event_c   = 1'b0;

    if (valid) begin
      if (!legal_c) begin
        illegal_d   = 1'b1;
        err_event_c = 1'b1;
        locked_d    = 1'b0;
        state_d     = S_SEARCH;
      end else begin
        index_d       = dec_idx_c;
        index_valid_d = 1'b1;
        prev_d        = dec_idx_c;
        case (state_q)
          S_SEARCH: begin
            good_d  = '0;
            state_d = S_TRACK;
          end
          S_TRACK: begin
            if (step_ok_c) begin
              good_d = good_q + GW'(1);
              if ((good_q + GW'(1)) >= GOOD_LOCK) begin
                state_d  = S_LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              seq_err_d   = 1'b1;
              err_event_c = 1'b1;
              good_d      = '0;
            end
          end
          S_LOCKED: begin
            if (!step_ok_c) begin
              seq_err_d   = 1'b1;
              err_event_c = 1'b1;
              locked_d    = 1'b0;
              good_d      = '0;
              state_d     = S_TRACK;
            end
          end
          default: begin
            locked_d = 1'b0;
            good_d   = '0;
            state_d  = S_SEARCH;
          end
        endcase
      end
    end

    if (err_event_c && (err_q != ERR_MAX)) begin
      err_d = err_q + EW'(1);
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign illegal     = illegal_q;
  assign seq_err     = seq_err_q;
  assign locked      = locked_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Directed bench for johnson_decoder_checker, N=4, LOCK_CNT=3; u_dut rejects holds, u_hold accepts them.
module tb_johnson_decoder_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] code_in = 4'h0;

  logic [2:0] idx0, idx1;
  logic       iv0, iv1, il0, il1, se0, se1, lk0, lk1;
  logic [7:0] ec0, ec1;

  int errors = 0;
  int checks = 0;

  logic [3:0] seq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [3:0] junk [5] = '{4'h5, 4'hA, 4'hF, 4'h0, 4'h9};

  always #5 clk = ~clk;

  johnson_decoder_checker #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(0)) u_dut (
    .clk(clk), .reset(reset), .valid(valid), .code_in(code_in),
    .index(idx0), .index_valid(iv0), .illegal(il0), .seq_err(se0),
    .locked(lk0), .err_count(ec0)
  );

  johnson_decoder_checker #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(1)) u_hold (
    .clk(clk), .reset(reset), .valid(valid), .code_in(code_in),
    .index(idx1), .index_valid(iv1), .illegal(il1), .seq_err(se1),
    .locked(lk1), .err_count(ec1)
  );

  // Apply one sample on the falling edge and return just after the capturing edge
  task automatic step(input logic r, input logic v, input logic [3:0] c);
    @(negedge clk);
    reset = r; valid = v; code_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    checks++; if (idx0 !== 3'd0 || iv0 !== 1'b0 || il0 !== 1'b0 || se0 !== 1'b0 || lk0 !== 1'b0 || ec0 !== 8'd0) begin
      errors++; $display("FAIL reset_dut: idx=%0d iv=%b il=%b se=%b lk=%b ec=%0d required all zero", idx0, iv0, il0, se0, lk0, ec0); end
    checks++; if (idx1 !== 3'd0 || iv1 !== 1'b0 || il1 !== 1'b0 || se1 !== 1'b0 || lk1 !== 1'b0 || ec1 !== 8'd0) begin
      errors++; $display("FAIL reset_hold: idx=%0d iv=%b il=%b se=%b lk=%b ec=%0d required all zero", idx1, iv1, il1, se1, lk1, ec1); end
  endtask

  task automatic test_lock_wrap();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, seq[i % 8]);
      checks++; if (idx0 !== 3'(i % 8) || iv0 !== 1'b1) begin
        errors++; $display("FAIL lock_index s%0d: idx=%0d iv=%b required idx=%0d iv=1", i, idx0, iv0, i % 8); end
      checks++; if (il0 !== 1'b0 || se0 !== 1'b0 || ec0 !== 8'd0) begin
        errors++; $display("FAIL lock_noerr s%0d: il=%b se=%b ec=%0d required 0 0 0", i, il0, se0, ec0); end
      checks++; if (lk0 !== (i >= 3) || lk1 !== (i >= 3)) begin
        errors++; $display("FAIL lock_locked s%0d: dut=%b hold=%b required %b", i, lk0, lk1, (i >= 3)); end
    end
  endtask

  task automatic test_illegal();
    step(1'b0, 1'b1, 4'h5);
    checks++; if (il0 !== 1'b1 || se0 !== 1'b0 || iv0 !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse: il=%b se=%b iv=%b required 1 0 0", il0, se0, iv0); end
    checks++; if (lk0 !== 1'b0 || idx0 !== 3'd3 || ec0 !== 8'd1) begin
      errors++; $display("FAIL illegal_state: lk=%b idx=%0d ec=%0d required 0 3 1", lk0, idx0, ec0); end
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 1'b1, seq[4 + j]);
      checks++; if (idx0 !== 3'(4 + j) || il0 !== 1'b0 || se0 !== 1'b0 || lk0 !== (j == 3)) begin
        errors++; $display("FAIL illegal_relock s%0d: idx=%0d il=%b se=%b lk=%b required %0d 0 0 %b", j, idx0, il0, se0, lk0, 4 + j, (j == 3)); end
    end
  endtask

  task automatic test_skip();
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b1, seq[j]);
      checks++; if (idx0 !== 3'(j) || lk0 !== 1'b1 || se0 !== 1'b0) begin
        errors++; $display("FAIL skip_pre s%0d: idx=%0d lk=%b se=%b required %0d 1 0", j, idx0, lk0, se0, j); end
    end
    step(1'b0, 1'b1, 4'hF);
    checks++; if (se0 !== 1'b1 || il0 !== 1'b0 || iv0 !== 1'b1 || idx0 !== 3'd4) begin
      errors++; $display("FAIL skip_seqerr: se=%b il=%b iv=%b idx=%0d required 1 0 1 4", se0, il0, iv0, idx0); end
    checks++; if (lk0 !== 1'b0 || ec0 !== 8'd2) begin
      errors++; $display("FAIL skip_state: lk=%b ec=%0d required 0 2", lk0, ec0); end
    for (int j = 1; j < 4; j++) begin
      step(1'b0, 1'b1, seq[4 + j]);
      checks++; if (idx0 !== 3'(4 + j) || se0 !== 1'b0 || lk0 !== (j == 3)) begin
        errors++; $display("FAIL skip_relock s%0d: idx=%0d se=%b lk=%b required %0d 0 %b", j, idx0, se0, lk0, 4 + j, (j == 3)); end
    end
  endtask

  task automatic test_hold();
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, seq[j]);
    checks++; if (lk0 !== 1'b1 || lk1 !== 1'b1 || idx0 !== 3'd3) begin
      errors++; $display("FAIL hold_pre: dut lk=%b hold lk=%b idx=%0d required 1 1 3", lk0, lk1, idx0); end
    step(1'b0, 1'b1, 4'h7);
    checks++; if (se0 !== 1'b1 || lk0 !== 1'b0 || ec0 !== 8'd3 || idx0 !== 3'd3 || iv0 !== 1'b1) begin
      errors++; $display("FAIL hold_reject: se=%b lk=%b ec=%0d idx=%0d iv=%b required 1 0 3 3 1", se0, lk0, ec0, idx0, iv0); end
    checks++; if (se1 !== 1'b0 || il1 !== 1'b0 || lk1 !== 1'b1 || ec1 !== 8'd2 || iv1 !== 1'b1) begin
      errors++; $display("FAIL hold_accept: se=%b il=%b lk=%b ec=%0d iv=%b required 0 0 1 2 1", se1, il1, lk1, ec1, iv1); end
  endtask

  task automatic test_valid_gating();
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b0, junk[j]);
      checks++; if (iv0 !== 1'b0 || il0 !== 1'b0 || se0 !== 1'b0 || idx0 !== 3'd3 || lk0 !== 1'b0 || ec0 !== 8'd3) begin
        errors++; $display("FAIL gate_dut c%0d: iv=%b il=%b se=%b idx=%0d lk=%b ec=%0d required 0 0 0 3 0 3", j, iv0, il0, se0, idx0, lk0, ec0); end
      checks++; if (iv1 !== 1'b0 || il1 !== 1'b0 || lk1 !== 1'b1 || ec1 !== 8'd2) begin
        errors++; $display("FAIL gate_hold c%0d: iv=%b il=%b lk=%b ec=%0d required 0 0 1 2", j, iv1, il1, lk1, ec1); end
    end
    step(1'b0, 1'b1, seq[4]);
    checks++; if (idx0 !== 3'd4 || se0 !== 1'b0 || ec0 !== 8'd3 || se1 !== 1'b0 || lk1 !== 1'b1 || ec1 !== 8'd2) begin
      errors++; $display("FAIL gate_resume: idx=%0d se=%b ec=%0d hse=%b hlk=%b hec=%0d required 4 0 3 0 1 2", idx0, se0, ec0, se1, lk1, ec1); end
    step(1'b1, 1'b1, 4'h5);
    checks++; if (idx0 !== 3'd0 || iv0 !== 1'b0 || il0 !== 1'b0 || se0 !== 1'b0 || lk0 !== 1'b0 || ec0 !== 8'd0) begin
      errors++; $display("FAIL midreset_dut: idx=%0d iv=%b il=%b se=%b lk=%b ec=%0d required all zero", idx0, iv0, il0, se0, lk0, ec0); end
    checks++; if (idx1 !== 3'd0 || lk1 !== 1'b0 || ec1 !== 8'd0 || il1 !== 1'b0) begin
      errors++; $display("FAIL midreset_hold: idx=%0d lk=%b ec=%0d il=%b required 0 0 0 0", idx1, lk1, ec1, il1); end
    step(1'b0, 1'b1, seq[6]);
    checks++; if (iv0 !== 1'b1 || se0 !== 1'b0 || idx0 !== 3'd6 || lk0 !== 1'b0 || ec0 !== 8'd0) begin
      errors++; $display("FAIL postreset: iv=%b se=%b idx=%0d lk=%b ec=%0d required 1 0 6 0 0", iv0, se0, idx0, lk0, ec0); end
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 1'b1, 4'hA);
      checks++; if (il0 !== 1'b1 || se0 !== 1'b0 || ec0 !== 8'((k > 255) ? 255 : k)) begin
        errors++; $display("FAIL sat_dut n%0d: il=%b se=%b ec=%0d required 1 0 %0d", k, il0, se0, ec0, (k > 255) ? 255 : k); end
    end
    checks++; if (ec1 !== 8'd255 || il1 !== 1'b1 || idx1 !== 3'd6) begin
      errors++; $display("FAIL sat_hold: ec=%0d il=%b idx=%0d required 255 1 6", ec1, il1, idx1); end
    step(1'b0, 1'b1, seq[2]);
    checks++; if (il0 !== 1'b0 || se0 !== 1'b0 || iv0 !== 1'b1 || idx0 !== 3'd2 || ec0 !== 8'd255) begin
      errors++; $display("FAIL sat_recover: il=%b se=%b iv=%b idx=%0d ec=%0d required 0 0 1 2 255", il0, se0, iv0, idx0, ec0); end
  endtask

  initial begin
    test_reset();
    test_lock_wrap();
    test_illegal();
    test_skip();
    test_hold();
    test_valid_gating();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
